// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler
// Round-robin front end that lets NUM_REQ requesters share one 64x64 Booth
// multiplier. Each accepted request walks the multiplier through
// CLR -> START -> WAIT and then holds the product in RESP until it is consumed.
// Only one operation is in flight at a time.
//
// Optional build macro: MUL_RR_SCHED_TIMEOUT_EN
//   Adds parameter TIMEOUT_CYC, an 8-bit WAIT watchdog and output rsp_error.
//   If the watchdog expires, the multiplier is cleared and a zero result is
//   returned with rsp_error set.

module mul_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
`ifdef MUL_RR_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_multiplier,
  input  logic [NUM_REQ*DATA_W-1:0] req_multiplicand,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*DATA_W-1:0]       rsp_result,
  output logic [2:0]                rsp_id,
  output logic                      mul_op_start,
  output logic                      mul_op_clear,
  output logic [DATA_W-1:0]         mul_multiplier,
  output logic [DATA_W-1:0]         mul_multiplicand,
  input  logic                      mul_op_done,
  input  logic [2*DATA_W-1:0]       mul_result,
`ifdef MUL_RR_SCHED_TIMEOUT_EN
  output logic                      rsp_error,
`endif
  output logic                      busy
);

  // Index width for requester numbers (at least one bit).
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // State and datapath registers.
  state_e                state_q, state_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      id_q, id_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [DATA_W-1:0]     mcand_q, mcand_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

`ifdef MUL_RR_SCHED_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       timeout_s;
`endif

  // Arbitration signals.
  logic                  win_found_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic [IDX_W:0]        cand_sum_s;
  logic [IDX_W-1:0]      cand_idx_s;
  logic                  take_s;
  logic [DATA_W-1:0]     sel_mplier_s;
  logic [DATA_W-1:0]     sel_mcand_s;

  // Round-robin search: first valid requester at or above rr_q, with wrap.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_sum_s  = '0;
    cand_idx_s  = '0;
    take_s      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum_s  = {1'b0, rr_q} + (IDX_W + 1)'(k);
      cand_sum_s  = (cand_sum_s >= NUM_REQ_W) ? (cand_sum_s - NUM_REQ_W) : cand_sum_s;
      cand_idx_s  = cand_sum_s[IDX_W-1:0];
      take_s      = (!win_found_s) && req_valid[cand_idx_s];
      win_idx_s   = take_s ? cand_idx_s : win_idx_s;
      win_found_s = win_found_s | take_s;
    end
  end

  // Operand selection for the arbitration winner.
  always_comb begin
    sel_mplier_s = '0;
    sel_mcand_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_mplier_s = (win_idx_s == IDX_W'(i)) ? req_multiplier[i*DATA_W +: DATA_W]   : sel_mplier_s;
      sel_mcand_s  = (win_idx_s == IDX_W'(i)) ? req_multiplicand[i*DATA_W +: DATA_W] : sel_mcand_s;
    end
  end

  // Accept pulse: combinational so the requester sees it in the accept cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_q == ST_IDLE) && win_found_s && (win_idx_s == IDX_W'(i));
    end
  end

`ifdef MUL_RR_SCHED_TIMEOUT_EN
  // Watchdog fires when WAIT has lasted TIMEOUT_CYC cycles without done.
  always_comb begin
    timeout_s = (state_q == ST_WAIT) && !mul_op_done && (wd_q == WD_LAST);
  end
`endif

  // Next-state and datapath update logic.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    id_d     = id_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    result_d = result_q;
`ifdef MUL_RR_SCHED_TIMEOUT_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          id_d     = win_idx_s;
          mplier_d = sel_mplier_s;
          mcand_d  = sel_mcand_s;
          state_d  = ST_CLR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CLR: begin
        // The multiplier's bit counter only restarts after a clear.
        state_d = ST_START;
      end
      ST_START: begin
`ifdef MUL_RR_SCHED_TIMEOUT_EN
        wd_d    = 8'd0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_op_done) begin
          result_d = mul_result;
          state_d  = ST_RESP;
        end else begin
`ifdef MUL_RR_SCHED_TIMEOUT_EN
          wd_d = wd_q + 8'd1;
          if (timeout_s) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_WAIT;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rr_d    = (id_q == LAST_IDX) ? '0 : (id_q + IDX_W'(1));
`ifdef MUL_RR_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      result_q <= '0;
`ifdef MUL_RR_SCHED_TIMEOUT_EN
      wd_q     <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
`ifdef MUL_RR_SCHED_TIMEOUT_EN
      wd_q     <= wd_d;
      err_q    <= err_d;
`endif
    end
  end

  // Response valid is one-hot on the latched requester index while in RESP.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == ST_RESP) && (id_q == IDX_W'(i));
    end
  end

  // Remaining outputs decode directly from registered state.
  always_comb begin
    busy             = (state_q != ST_IDLE);
    mul_op_start     = (state_q == ST_START);
`ifdef MUL_RR_SCHED_TIMEOUT_EN
    mul_op_clear     = (state_q == ST_CLR) || timeout_s;
    rsp_error        = err_q;
`else
    mul_op_clear     = (state_q == ST_CLR);
`endif
    mul_multiplier   = mplier_q;
    mul_multiplicand = mcand_q;
    rsp_result       = result_q;
    rsp_id           = (state_q == ST_RESP) ? 3'(id_q) : 3'd0;
  end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed testbench for mul_rr_scheduler with a behavioural stand-in for
// the Booth multiplier. The stand-in only produces a correct product when a
// clear preceded the start, and scrambles mul_result after each done pulse.

module tb_mul_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_multiplier;
  logic [NUM_REQ*DATA_W-1:0] req_multiplicand;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic                      rsp_ready;
  logic [2*DATA_W-1:0]       rsp_result;
  logic [2:0]                rsp_id;
  logic                      mul_op_start;
  logic                      mul_op_clear;
  logic [DATA_W-1:0]         mul_multiplier;
  logic [DATA_W-1:0]         mul_multiplicand;
  logic                      mul_op_done = 1'b0;
  logic [2*DATA_W-1:0]       mul_result = '0;
  logic                      busy;
`ifdef MUL_RR_SCHED_TIMEOUT_EN
  logic                      rsp_error;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_id           (rsp_id),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result),
`ifdef MUL_RR_SCHED_TIMEOUT_EN
    .rsp_error        (rsp_error),
`endif
    .busy             (busy)
  );

  // ---------------- multiplier stand-in ----------------
  logic        m_run = 1'b0;
  logic        m_cleared = 1'b0;
  logic        m_ok = 1'b0;
  logic        m_hang = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 129;
  logic [63:0] m_a = '0;
  logic [63:0] m_b = '0;

  function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] x;
    logic signed [127:0] y;
    x = {{64{a[63]}}, a};
    y = {{64{b[63]}}, b};
    return x * y;
  endfunction

  // Behavioural multiplier: clear aborts/arms, start runs, done after m_lat cycles.
  always @(posedge clk) begin
    mul_op_done <= 1'b0;
    if (mul_op_done) begin
      mul_result <= {4{32'hA5A5_5A5A}};
    end
    if (mul_op_clear) begin
      m_run     <= 1'b0;
      m_cleared <= 1'b1;
    end else if (mul_op_start) begin
      m_run     <= 1'b1;
      m_cnt     <= 0;
      m_ok      <= m_cleared;
      m_cleared <= 1'b0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 0) begin
        m_a <= mul_multiplier;
        m_b <= mul_multiplicand;
      end
      if (m_cnt == m_lat && !m_hang) begin
        mul_op_done <= 1'b1;
        mul_result  <= m_ok ? smul(m_a, m_b) : {2{64'hDEAD_BEEF_0BAD_F00D}};
        m_run       <= 1'b0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] id);
    logic [3:0] one;
    one = 4'b0001;
    return one << id;
  endfunction

  task automatic set_slot(input logic [1:0] id, input logic [63:0] a, input logic [63:0] b);
    logic [7:0] base;
    base = {id, 6'b000000};
    req_multiplier[base +: 64]   = a;
    req_multiplicand[base +: 64] = b;
  endtask

  // Waits (bounded) at negedges until req_ready shows something.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0000 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check_value({tag, "_ready_timeout"}, 256'd0, 256'd1);
  endtask

  // Waits (bounded) at negedges until a response is presented.
  task automatic wait_rsp(input string tag, output bit extra_ready);
    int n;
    n = 0;
    extra_ready = 1'b0;
    while (rsp_valid == 4'b0000 && n < 600) begin
      if (req_ready != 4'b0000) extra_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 600) check_value({tag, "_rsp_timeout"}, 256'd0, 256'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // One complete operation from a single requester, called at a negedge.
  task automatic do_op(input string tag, input logic [1:0] id, input logic [63:0] a,
                       input logic [63:0] b, input logic [127:0] exp);
    bit extra;
    set_slot(id, a, b);
    req_valid[id] = 1'b1;
    wait_ready(tag);
    check_value({tag, "_ready"}, 256'(req_ready), 256'(onehot(id)));
    @(negedge clk);
    req_valid[id] = 1'b0;
    check_value({tag, "_clr"}, 256'({mul_op_clear, mul_op_start}), 256'(2'b10));
    @(negedge clk);
    check_value({tag, "_start"}, 256'({mul_op_clear, mul_op_start}), 256'(2'b01));
    @(negedge clk);
    check_value({tag, "_operands"}, 256'({mul_multiplier, mul_multiplicand}), 256'({a, b}));
    wait_rsp(tag, extra);
    check_value({tag, "_rsp_valid"}, 256'(rsp_valid), 256'(onehot(id)));
    check_value({tag, "_rsp_id"}, 256'(rsp_id), 256'({1'b0, id}));
    check_value({tag, "_result"}, 256'(rsp_result), 256'(exp));
    consume();
    check_value({tag, "_idle"}, 256'({busy, rsp_valid}), 256'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_value("reset_ctrl", 256'({busy, req_ready, rsp_valid, rsp_id, mul_op_start, mul_op_clear,
                                    mul_multiplier, mul_multiplicand}), 256'd0);
    check_value("reset_result", 256'(rsp_result), 256'd0);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] rr_exp [5];
  bit           extra;

  initial begin
    reset            = 1'b1;
    req_valid        = '0;
    req_multiplier   = '0;
    req_multiplicand = '0;
    rsp_ready        = 1'b0;
    @(negedge clk);
    do_reset();

    // Basic, signed and back-to-back operations.
    do_op("single_r1", 2'd1, 64'd3, 64'd5, 128'd15);
    do_op("signed_r0", 2'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);
    m_lat = 193;
    do_op("b2b_first", 2'd0, 64'h2, 64'h3, 128'd6);
    m_lat = 160;
    do_op("b2b_second", 2'd0, 64'h10, 64'h10, 128'd256);
    m_lat = 129;

    // All requesters valid: round-robin order 0,1,2,3,0 from a fresh pointer.
    do_reset();
    rr_exp[0] = 128'd2;
    rr_exp[1] = 128'd12;
    rr_exp[2] = 128'd30;
    rr_exp[3] = 128'd56;
    rr_exp[4] = 128'd90;
    set_slot(2'd0, 64'd1, 64'd2);
    set_slot(2'd1, 64'd3, 64'd4);
    set_slot(2'd2, 64'd5, 64'd6);
    set_slot(2'd3, 64'd7, 64'd8);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready("rr");
      check_value("rr_grant", 256'(req_ready), 256'(onehot(2'(k % 4))));
      @(negedge clk);
      if (k == 0) set_slot(2'd0, 64'd9, 64'd10);
      wait_rsp("rr", extra);
      check_value("rr_no_extra_ready", 256'(extra), 256'd0);
      check_value("rr_rsp", 256'({rsp_valid, rsp_id}), 256'({onehot(2'(k % 4)), 3'(k % 4)}));
      check_value("rr_result", 256'(rsp_result), 256'(rr_exp[k]));
      if (k == 1) begin
        // Backpressure: response must hold still for 10 cycles.
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check_value("bp_ctrl", 256'({busy, req_ready, rsp_valid, rsp_id}),
                      256'({1'b1, 4'b0000, 4'b0010, 3'd1}));
          check_value("bp_result", 256'(rsp_result), 256'd12);
        end
      end
      consume();
    end
    req_valid = 4'b0000;
    @(negedge clk);

    // Reset while the multiplier is running.
    set_slot(2'd2, 64'd9, 64'd9);
    req_valid[2] = 1'b1;
    wait_ready("rstwait");
    @(negedge clk);
    req_valid[2] = 1'b0;
    repeat (6) @(negedge clk);
    check_value("rstwait_busy", 256'({busy, rsp_valid}), 256'({1'b1, 4'b0000}));
    reset = 1'b1;
    @(negedge clk);
    check_value("rstwait_ctrl", 256'({busy, req_ready, rsp_valid, rsp_id, mul_op_start, mul_op_clear,
                                      mul_multiplier, mul_multiplicand}), 256'd0);
    check_value("rstwait_result", 256'(rsp_result), 256'd0);
    reset = 1'b0;
    do_op("rst_recover", 2'd3, 64'd4, 64'd4, 128'd16);

`ifdef MUL_RR_SCHED_TIMEOUT_EN
    // Multiplier never answers: watchdog returns zero with an error flag.
    m_hang = 1'b1;
    set_slot(2'd1, 64'd3, 64'd3);
    req_valid[1] = 1'b1;
    wait_ready("timeout");
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp("timeout", extra);
    check_value("timeout_rsp", 256'({rsp_error, rsp_valid, rsp_id}), 256'({1'b1, 4'b0010, 3'd1}));
    check_value("timeout_result", 256'(rsp_result), 256'd0);
    consume();
    check_value("timeout_err_clr", 256'(rsp_error), 256'd0);
    m_hang = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
